// File: rtl/dds_nco_pipe.sv
// dds_nco_pipe: pipelined DDS/NCO with a modulo-2^PHASE_W phase accumulator,
// a phase-offset input, and square, sawtooth and folded-triangle waveforms.
// A registered unsigned amplitude scale follows the waveform stage.
// New tuning words are accepted by a valid/ready handshake. They are applied
// phase-coherently when the accumulator wraps.
//
// Ports:
//   clk_in        clock, rising edge
//   rst_in        synchronous active-high reset
//   enable_in     run; low zeroes the phase, samples in flight drain
//   ftw_in        new frequency tuning word (zero-extended to PHASE_W)
//   ftw_valid_in  ftw_in valid
//   ftw_ready_out high when a new tuning word can be accepted
//   phase_ofs_in  phase offset added before waveform generation
//   wavesel_in    00 off, 01 square, 10 sawtooth, 11 triangle
//   duty_in       square threshold compared against truncated phase
//   amp_in        unsigned amplitude scale
//   wave_out      signed scaled sample
//   valid_out     wave_out holds a live sample
//   sync_out      pulse on the first sample taken from a wrapped phase
module dds_nco_pipe #(
  parameter int PHASE_W = 16,
  parameter int FTW_W   = 16,
  parameter int OUT_W   = 8,
  parameter int AMP_W   = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic [FTW_W-1:0]   ftw_in,
  input  logic               ftw_valid_in,
  output logic               ftw_ready_out,
  input  logic [PHASE_W-1:0] phase_ofs_in,
  input  logic [1:0]         wavesel_in,
  input  logic [OUT_W-1:0]   duty_in,
  input  logic [AMP_W-1:0]   amp_in,
  output logic [OUT_W-1:0]   wave_out,
  output logic               valid_out,
  output logic               sync_out
);

  localparam int PROD_W = OUT_W + AMP_W + 1;

  typedef enum logic [1:0] {
    WAVE_OFF = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_SAW = 2'b10,
    WAVE_TRI = 2'b11
  } wave_e;

  // Stage A: accumulator and tuning-word handling
  logic [PHASE_W-1:0] phase_reg;
  logic               carry_a;
  logic               en_a;
  logic [FTW_W-1:0]   active_ftw;
  logic [FTW_W-1:0]   pend_ftw;
  logic               pending;
  logic [PHASE_W:0]   acc_sum;
  logic               apply_now;

  // Stage B: waveform
  logic [PHASE_W-1:0] ofs_sum;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-2:0]   q;
  wave_e              wave_sel;
  logic [OUT_W-1:0]   wave_nxt;
  logic signed [OUT_W-1:0] wave_b;
  logic               en_b;
  logic               sync_b;

  // Stage C: amplitude scaling
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;
  logic                     unused_bits;

  assign ftw_ready_out = !pending;

  always_comb begin
    acc_sum   = {1'b0, phase_reg} + {1'b0, PHASE_W'(active_ftw)};
    // A zero active word would never wrap, so a pending word applies at once.
    apply_now = pending && ((enable_in && acc_sum[PHASE_W]) || !enable_in ||
                            (active_ftw == '0));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_reg  <= '0;
      carry_a    <= 1'b0;
      en_a       <= 1'b0;
      active_ftw <= '0;
      pend_ftw   <= '0;
      pending    <= 1'b0;
    end else begin
      en_a <= enable_in;
      if (enable_in) begin
        phase_reg <= acc_sum[PHASE_W-1:0];
        carry_a   <= acc_sum[PHASE_W];
      end else begin
        phase_reg <= '0;
        carry_a   <= 1'b0;
      end
      if (apply_now) begin
        active_ftw <= pend_ftw;
        pending    <= 1'b0;
      end else if (ftw_valid_in && !pending) begin
        pend_ftw <= ftw_in;
        pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    ofs_sum  = phase_reg + phase_ofs_in;
    p        = ofs_sum[PHASE_W-1 -: OUT_W];
    q        = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    wave_sel = wave_e'(wavesel_in);
    wave_nxt = '0;
    case (wave_sel)
      WAVE_SQR: wave_nxt = (p < duty_in) ? {1'b0, {(OUT_W-1){1'b1}}}
                                         : {1'b1, {(OUT_W-1){1'b0}}};
      WAVE_SAW: wave_nxt = {~p[OUT_W-1], p[OUT_W-2:0]};
      // (q<<1) - 2^(OUT_W-1) in OUT_W bits is {q,0} with its MSB inverted
      WAVE_TRI: wave_nxt = {~q[OUT_W-2], q[OUT_W-3:0], 1'b0};
      default:  wave_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wave_b <= '0;
      en_b   <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      wave_b <= wave_nxt;
      en_b   <= en_a;
      sync_b <= carry_a && en_a;
    end
  end

  always_comb begin
    product = PROD_W'(wave_b) * PROD_W'($signed({1'b0, amp_in}));
    shifted = product >>> AMP_W;
  end

  assign unused_bits = ^{ofs_sum, shifted};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wave_out  <= '0;
      valid_out <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      valid_out <= en_b;
      sync_out  <= sync_b && en_b;
      wave_out  <= en_b ? shifted[OUT_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_dds_nco_pipe.sv
module tb_dds_nco_pipe;

  logic        clk = 1'b0;
  logic        rst, en, ftw_v, ready;
  logic [15:0] ftw, ofs;
  logic [1:0]  wsel;
  logic [7:0]  duty, amp, wave;
  logic        valid, sync;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  always #5 clk = ~clk;

  dds_nco_pipe #(.PHASE_W(16), .FTW_W(16), .OUT_W(8), .AMP_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .ftw_in(ftw),
    .ftw_valid_in(ftw_v), .ftw_ready_out(ready), .phase_ofs_in(ofs),
    .wavesel_in(wsel), .duty_in(duty), .amp_in(amp),
    .wave_out(wave), .valid_out(valid), .sync_out(sync)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: phase as a plain integer, waveform from the arithmetic
  // definitions, and the two-stage delay expressed as a held B-stage sample.
  int m_phase, m_active, m_pend;
  bit m_live, m_wrap, m_pending;
  int b_val;
  bit b_live, b_sync;
  int e_wave;
  bit e_valid, e_sync;

  function automatic int wave_of(int ph, int o, int ws, int d);
    int pp;
    pp = ((ph + o) % 65536) / 256;
    case (ws)
      1:       return (pp < d) ? 127 : -128;
      2:       return pp - 128;
      3:       return (pp < 128) ? 2 * pp - 128 : 2 * (255 - pp) - 128;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int sum;
    bit wrapped;
    started = 1;
    if (rst) begin
      m_phase = 0; m_live = 0; m_wrap = 0; m_active = 0; m_pend = 0;
      m_pending = 0; b_val = 0; b_live = 0; b_sync = 0;
      e_wave = 0; e_valid = 0; e_sync = 0;
    end else begin
      e_valid = b_live;
      e_sync  = b_live && b_sync;
      e_wave  = b_live ? ((b_val * int'(amp)) >>> 8) : 0;
      b_val   = wave_of(m_phase, int'(ofs), int'(wsel), int'(duty));
      b_live  = m_live;
      b_sync  = m_live && m_wrap;
      sum     = m_phase + m_active;
      wrapped = en && (sum >= 65536);
      if (m_pending && (wrapped || !en || m_active == 0)) begin
        m_active  = m_pend;
        m_pending = 0;
      end else if (ftw_v && !m_pending) begin
        m_pend    = int'(ftw);
        m_pending = 1;
      end
      m_phase = en ? sum % 65536 : 0;
      m_wrap  = wrapped;
      m_live  = en;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wave",  int'($signed(wave)), e_wave);
      chk("valid", int'(valid), int'(e_valid));
      chk("sync",  int'(sync),  int'(e_sync));
      chk("ready", int'(ready), int'(!m_pending));
    end
  end

  initial begin
    int tri_ofs[4];
    int tri_exp[4];
    tri_ofs = '{'h0000, 'h7F00, 'h8000, 'hFF00};
    tri_exp = '{-128, 125, 125, -128};

    rst = 1; en = 0; ftw = '0; ftw_v = 0; ofs = '0; wsel = 2'b00;
    duty = '0; amp = '0;
    repeat (2) @(negedge clk);
    chk("rst_wave", int'(wave), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ready", int'(ready), 1);
    rst = 0;

    // Sawtooth at FTW 0x1000: loaded while disabled, applied on the next edge
    ftw = 16'h1000; ftw_v = 1;
    @(negedge clk);
    ftw_v = 0;
    chk("t1_ready_low", int'(ready), 0);
    @(negedge clk);
    chk("t1_ready_back", int'(ready), 1);
    wsel = 2'b10; amp = 8'd255; ofs = '0; en = 1;
    for (int i = 0; i < 8 && !valid; i++) @(negedge clk);
    chk("t1_first_valid", int'(valid), 1);
    chk("t1_first_wave", int'($signed(wave)), -112);
    chk("t1_model_first", e_wave, -112);
    @(negedge clk);
    chk("t1_second_wave", int'($signed(wave)), -96);
    repeat (40) @(negedge clk);

    // Offer a new word mid-period: held pending until the wrap
    ftw = 16'h2000; ftw_v = 1;
    @(negedge clk);
    ftw_v = 0;
    chk("t3_ready_low", int'(ready), 0);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    chk("t3_ready_back", int'(ready), 1);
    repeat (30) @(negedge clk);

    // Triangle with FTW 0 and a stepped offset
    rst = 1;
    @(negedge clk);
    rst = 0; en = 1; wsel = 2'b11; amp = 8'd255;
    for (int i = 0; i < 4; i++) begin
      ofs = 16'(tri_ofs[i]);
      repeat (3) @(negedge clk);
      chk("t2_tri", int'($signed(wave)), tri_exp[i]);
      chk("t2_model_tri", e_wave, tri_exp[i]);
    end

    // Square, duty 64, FTW 0x0100 (applies at once since the active word is 0)
    ofs = '0; wsel = 2'b01; duty = 8'd64; ftw = 16'h0100; ftw_v = 1;
    @(negedge clk);
    ftw_v = 0;
    repeat (4) @(negedge clk);
    chk("t4_high", int'($signed(wave)), 126);
    repeat (600) @(negedge clk);

    // Zero amplitude, off waveform, then amplitude change
    amp = 8'd0;  repeat (6) @(negedge clk);
    chk("t5_amp0", int'($signed(wave)), 0);
    chk("t5_amp0_valid", int'(valid), 1);
    amp = 8'd255; wsel = 2'b00; repeat (6) @(negedge clk);
    chk("t5_off", int'($signed(wave)), 0);
    wsel = 2'b10; repeat (6) @(negedge clk);
    amp = 8'd128; repeat (6) @(negedge clk);

    // Reset mid-run with a word offered throughout
    ftw = 16'h0300; ftw_v = 1; rst = 1;
    @(negedge clk);
    chk("t6_wave", int'(wave), 0);
    chk("t6_valid", int'(valid), 0);
    chk("t6_sync", int'(sync), 0);
    chk("t6_ready", int'(ready), 1);
    rst = 0; ftw_v = 0;
    @(negedge clk);
    chk("t6_no_capture", int'(ready), 1);
    repeat (10) @(negedge clk);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 31) == 0) en = ~en;
      ftw_v = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       ftw = 16'h0000;
        1:       ftw = 16'(1 << $urandom_range(8, 14));
        default: ftw = 16'($urandom_range(1, 65535));
      endcase
      if ($urandom_range(0, 15) == 0) wsel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)  amp  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)  ofs  = 16'($urandom_range(0, 65535));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
